// File: rtl/systolic_result_drain_pkg.sv
// systolic_result_drain_pkg: shared types, default widths and saturation bounds for the result drain
`ifndef ARRAY_HEIGHT
`define ARRAY_HEIGHT 4
`endif
`ifndef ARRAY_WIDTH
`define ARRAY_WIDTH 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
package systolic_result_drain_pkg;
    typedef enum logic {IDLE, STREAM} drain_state_t;
    localparam int OUT_WIDTH_DEFAULT = 8;
    function automatic longint sat_hi(int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction
    function automatic longint sat_lo(int w);
        return -(longint'(1) << (w - 1));
    endfunction
    localparam longint SAT_MAX = sat_hi(OUT_WIDTH_DEFAULT);
    localparam longint SAT_MIN = sat_lo(OUT_WIDTH_DEFAULT);
endpackage

// File: rtl/systolic_result_drain_if.sv
// systolic_result_drain_if: row-per-beat valid/ready stream from the drain to the writeback path
interface systolic_result_drain_if
    import systolic_result_drain_pkg::*;
#(
    parameter int ARRAY_WIDTH = `ARRAY_WIDTH,
    parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT,
    parameter int IDX_W = 2
);
    logic out_valid;
    logic out_ready;
    logic out_last;
    logic [ARRAY_WIDTH-1:0][OUT_WIDTH-1:0] out_row;
    logic [IDX_W-1:0] out_row_idx;
    modport master(output out_valid, out_row, out_row_idx, out_last, input out_ready);
    modport slave(input out_valid, out_row, out_row_idx, out_last, output out_ready);
endinterface

// File: rtl/systolic_result_drain_requant_sat.sv
// requant_sat: one lane of round-half-up arithmetic right shift followed by saturation
module requant_sat
    import systolic_result_drain_pkg::*;
#(
    parameter int ACC_WIDTH = `ACC_WIDTH,
    parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT,
    parameter int SHIFT_W = $clog2(ACC_WIDTH)
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [SHIFT_W-1:0]   shift,
    output logic [OUT_WIDTH-1:0] q
);
    localparam logic signed [ACC_WIDTH:0] HI = (ACC_WIDTH + 1)'(sat_hi(OUT_WIDTH));
    localparam logic signed [ACC_WIDTH:0] LO = (ACC_WIDTH + 1)'(sat_lo(OUT_WIDTH));
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] half;
    logic signed [ACC_WIDTH:0] v;
    // one extra bit keeps acc + rounding half from overflowing before the shift
    always_comb begin
        ext = $signed({acc[ACC_WIDTH-1], acc});
        half = (shift == '0) ? '0 : (ACC_WIDTH + 1)'(1) << (shift - SHIFT_W'(1));
        v = (ext + half) >>> shift;
        q = (v > HI) ? HI[OUT_WIDTH-1:0] : (v < LO) ? LO[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
    end
endmodule

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the accumulator matrix, clears the array and streams requantized rows
`ifndef ARRAY_HEIGHT
`define ARRAY_HEIGHT 4
`endif
`ifndef ARRAY_WIDTH
`define ARRAY_WIDTH 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int ARRAY_HEIGHT = `ARRAY_HEIGHT,
    parameter int ARRAY_WIDTH = `ARRAY_WIDTH,
    parameter int ACC_WIDTH = `ACC_WIDTH,
    parameter int OUT_WIDTH = OUT_WIDTH_DEFAULT,
    parameter int SHIFT_W = $clog2(ACC_WIDTH),
    localparam int IDX_W = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic result_valid,
    input  logic [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] results,
    input  logic [SHIFT_W-1:0] shift,
    output logic acc_clear,
    output logic busy,
    output logic overrun,
    input  logic overrun_clear,
    systolic_result_drain_if.master drain
);
    drain_state_t state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic capture, fire, last;
    logic [ARRAY_HEIGHT-1:0][ARRAY_WIDTH-1:0][ACC_WIDTH-1:0] snap;
    logic [SHIFT_W-1:0] shift_q;
    logic [ARRAY_WIDTH-1:0][OUT_WIDTH-1:0] lane_q;

    assign busy = (state == STREAM);
    assign last = (idx == IDX_W'(ARRAY_HEIGHT - 1));
    assign fire = busy && drain.out_ready;
    assign drain.out_valid = busy;
    assign drain.out_last = busy && last;
    assign drain.out_row_idx = idx;
    assign drain.out_row = busy ? lane_q : '0;

    // capture only from IDLE; leave STREAM after the final row is accepted
    always_comb begin
        state_next = state;
        idx_next = idx;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (result_valid) begin
                    capture = 1'b1;
                    state_next = STREAM;
                    idx_next = '0;
                end
            end
            STREAM: begin
                if (fire) begin
                    state_next = last ? IDLE : STREAM;
                    idx_next = last ? '0 : idx + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // state, snapshot and sticky overrun; result_valid while busy only flags overrun
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            acc_clear <= 1'b0;
            overrun <= 1'b0;
            snap <= '0;
            shift_q <= '0;
        end else begin
            state <= state_next;
            idx <= idx_next;
            acc_clear <= capture;
            overrun <= (result_valid && busy) || (overrun && !overrun_clear);
            if (capture) begin
                snap <= results;
                shift_q <= shift;
            end
        end
    end

    for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_lane
        requant_sat #(
            .ACC_WIDTH(ACC_WIDTH),
            .OUT_WIDTH(OUT_WIDTH),
            .SHIFT_W(SHIFT_W)
        ) u_lane (
            .acc(snap[idx][c]),
            .shift(shift_q),
            .q(lane_q[c])
        );
    end
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: randomized scenario bench against a behavioural requantization model
module tb_systolic_result_drain;
    localparam int H = 4;
    localparam int W = 4;
    localparam int AW = 32;
    localparam int OW = 8;
    localparam int SW = 5;
    localparam int IW = 2;

    logic clk = 0;
    logic rst = 1;
    logic result_valid = 0;
    logic overrun_clear = 0;
    logic acc_clear, busy, overrun;
    logic [H-1:0][W-1:0][AW-1:0] results = '0;
    logic [SW-1:0] shift = '0;

    systolic_result_drain_if #(.ARRAY_WIDTH(W), .OUT_WIDTH(OW), .IDX_W(IW)) drain();

    systolic_result_drain #(
        .ARRAY_HEIGHT(H),
        .ARRAY_WIDTH(W),
        .ACC_WIDTH(AW),
        .OUT_WIDTH(OW),
        .SHIFT_W(SW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .result_valid(result_valid),
        .results(results),
        .shift(shift),
        .acc_clear(acc_clear),
        .busy(busy),
        .overrun(overrun),
        .overrun_clear(overrun_clear),
        .drain(drain)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    longint snap_m[H][W];
    int shift_m = 0;

    // reference: plain arithmetic rounding shift then clamp to the signed output range
    function automatic logic [OW-1:0] ref_q(longint a, int s);
        longint v;
        longint hi = (longint'(1) << (OW - 1)) - 1;
        longint lo = -(longint'(1) << (OW - 1));
        v = (s == 0) ? a : ((a + (longint'(1) << (s - 1))) >>> s);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v[OW-1:0];
    endfunction

    function automatic logic [W-1:0][OW-1:0] exp_row(int r);
        logic [W-1:0][OW-1:0] e;
        for (int c = 0; c < W; c++) e[c] = ref_q(snap_m[r][c], shift_m);
        return e;
    endfunction

    function automatic longint rnd_acc();
        case ($urandom_range(2))
            0: return longint'($urandom_range(400)) - 200;
            1: return longint'($urandom_range(10000)) - 5000;
            default: return longint'($signed($urandom()));
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                longint v = (kind == 0) ? longint'(4 * r + c) : rnd_acc();
                results[r][c] = AW'(v);
                snap_m[r][c] = v;
            end
    endtask

    task automatic set_shift(input int s);
        shift = SW'(s);
        shift_m = s;
    endtask

    task automatic pulse();
        result_valid = 1;
        tick();
        result_valid = 0;
    endtask

    task automatic stream_beats(input int ready_pct);
        int beat = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (!drain.out_valid) break;
            drain.out_ready = ($urandom_range(99) < ready_pct);
            total++;
            if (drain.out_row !== exp_row(beat) || drain.out_row_idx !== IW'(beat) || drain.out_last !== (beat == H - 1))
                $display("FAIL beat%0d: row=%h idx=%0d last=%b, want row=%h idx=%0d last=%b", beat, drain.out_row,
                         drain.out_row_idx, drain.out_last, exp_row(beat), beat, beat == H - 1);
            else passed++;
            if (drain.out_ready) beat++;
            tick();
        end
        total++;
        if (beat !== H || busy !== 1'b0) $display("FAIL beat_count: got %0d busy=%b, want %0d busy=0", beat, busy, H);
        else passed++;
        drain.out_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1;
        drain.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        for (int k = 0; k < 10; k++) begin
            total++;
            if ({drain.out_valid, acc_clear, busy, drain.out_last, overrun} !== 5'b0 || drain.out_row_idx !== '0 || drain.out_row !== '0)
                $display("FAIL reset_idle cyc%0d: valid=%b clr=%b busy=%b last=%b ovr=%b idx=%0d row=%h, want all 0", k,
                         drain.out_valid, acc_clear, busy, drain.out_last, overrun, drain.out_row_idx, drain.out_row);
            else passed++;
            tick();
        end
    endtask

    task automatic test_stream();
        load(0);
        set_shift(0);
        drain.out_ready = 1;
        pulse();
        for (int r = 0; r < H; r++) begin
            total++;
            if ({drain.out_valid, busy, drain.out_last, acc_clear, drain.out_row_idx} !== {1'b1, 1'b1, r == H - 1, r == 0, IW'(r)})
                $display("FAIL stream_ctl beat%0d: valid=%b busy=%b last=%b clr=%b idx=%0d", r, drain.out_valid, busy,
                         drain.out_last, acc_clear, drain.out_row_idx);
            else passed++;
            total++;
            if (drain.out_row !== exp_row(r)) $display("FAIL stream_row%0d: got %h want %h", r, drain.out_row, exp_row(r));
            else passed++;
            tick();
        end
        total++;
        if ({drain.out_valid, busy, acc_clear, drain.out_row_idx} !== '0)
            $display("FAIL stream_end: valid=%b busy=%b clr=%b idx=%0d, want 0", drain.out_valid, busy, acc_clear, drain.out_row_idx);
        else passed++;
    endtask

    task automatic test_backpressure();
        load(0);
        set_shift(0);
        drain.out_ready = 0;
        pulse();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (drain.out_valid !== 1'b1 || drain.out_row_idx !== '0 || drain.out_row !== exp_row(0))
                $display("FAIL hold cyc%0d: valid=%b idx=%0d row=%h, want 1 0 %h", k, drain.out_valid, drain.out_row_idx,
                         drain.out_row, exp_row(0));
            else passed++;
            tick();
        end
        drain.out_ready = 1;
        for (int r = 0; r < H; r++) begin
            total++;
            if (drain.out_row !== exp_row(r) || drain.out_row_idx !== IW'(r) || drain.out_last !== (r == H - 1))
                $display("FAIL bp_beat%0d: row=%h idx=%0d last=%b", r, drain.out_row, drain.out_row_idx, drain.out_last);
            else passed++;
            tick();
        end
        total++;
        if (busy !== 1'b0) $display("FAIL bp_end: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_requant();
        int s_tab[6] = '{0, 0, 1, 1, 2, 4};
        longint a_tab[6] = '{300, -300, 5, -5, 7, 64'h7FFFFFFF};
        int q_tab[6] = '{127, -128, 3, -2, 2, 127};
        for (int i = 0; i < 6; i++) begin
            load(1);
            results[0][0] = AW'(a_tab[i]);
            snap_m[0][0] = a_tab[i];
            set_shift(s_tab[i]);
            drain.out_ready = 1;
            pulse();
            total++;
            if (drain.out_row[0] !== OW'(q_tab[i]))
                $display("FAIL requant acc=%0d s=%0d: got %0d want %0d", a_tab[i], s_tab[i], $signed(drain.out_row[0]), q_tab[i]);
            else passed++;
            stream_beats(100);
        end
    endtask

    task automatic test_overrun();
        load(0);
        set_shift(0);
        drain.out_ready = 1;
        pulse();
        tick();
        result_valid = 1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) results[r][c] = $urandom();
        total++;
        if (drain.out_row !== exp_row(1)) $display("FAIL ovr_row1: got %h want %h", drain.out_row, exp_row(1));
        else passed++;
        tick();
        result_valid = 0;
        total++;
        if (overrun !== 1'b1 || acc_clear !== 1'b0 || drain.out_row_idx !== 2'd2 || drain.out_row !== exp_row(2))
            $display("FAIL ovr_set: ovr=%b clr=%b idx=%0d row=%h, want 1 0 2 %h", overrun, acc_clear, drain.out_row_idx,
                     drain.out_row, exp_row(2));
        else passed++;
        tick();
        total++;
        if (drain.out_row !== exp_row(3) || drain.out_last !== 1'b1) $display("FAIL ovr_row3: got %h last=%b", drain.out_row, drain.out_last);
        else passed++;
        tick();
        total++;
        if (busy !== 1'b0 || acc_clear !== 1'b0 || overrun !== 1'b1)
            $display("FAIL ovr_idle: busy=%b clr=%b ovr=%b, want 0 0 1", busy, acc_clear, overrun);
        else passed++;
        overrun_clear = 1;
        tick();
        overrun_clear = 0;
        total++;
        if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun);
        else passed++;
        load(1);
        pulse();
        repeat (H - 1) tick();
        result_valid = 1;
        overrun_clear = 1;
        tick();
        result_valid = 0;
        overrun_clear = 0;
        total++;
        if (busy !== 1'b0 || acc_clear !== 1'b0 || overrun !== 1'b1 || drain.out_valid !== 1'b0)
            $display("FAIL ovr_last_beat: busy=%b clr=%b ovr=%b valid=%b, want 0 0 1 0", busy, acc_clear, overrun, drain.out_valid);
        else passed++;
        overrun_clear = 1;
        tick();
        overrun_clear = 0;
    endtask

    task automatic test_reset_mid();
        load(1);
        set_shift($urandom_range(31));
        drain.out_ready = 1;
        pulse();
        tick();
        rst = 1;
        #1;
        total++;
        if ({drain.out_valid, busy, drain.out_last, overrun, drain.out_row_idx} !== '0)
            $display("FAIL rst_mid: valid=%b busy=%b last=%b ovr=%b idx=%0d, want 0", drain.out_valid, busy, drain.out_last,
                     overrun, drain.out_row_idx);
        else passed++;
        @(posedge clk);
        #1;
        rst = 0;
        total++;
        if ({drain.out_valid, acc_clear} !== 2'b0) $display("FAIL rst_hold: valid=%b clr=%b, want 0 0", drain.out_valid, acc_clear);
        else passed++;
        load(1);
        pulse();
        total++;
        if (acc_clear !== 1'b1 || drain.out_row_idx !== '0) $display("FAIL rst_restart: clr=%b idx=%0d, want 1 0", acc_clear, drain.out_row_idx);
        else passed++;
        stream_beats(100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            load(1);
            set_shift($urandom_range(31));
            pulse();
            set_shift($urandom_range(31));
            shift_m = int'(dut.shift_q);
            stream_beats(60);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_requant();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Reader side of the systolic array's result interface.
- Snapshots the full ARRAY_HEIGHT x ARRAY_WIDTH accumulator matrix when the array pulses result_valid.
- Clears the array's accumulators.
- Streams the snapshot out one row per beat on a valid/ready interface, requantized and saturated to OUT_WIDTH.
- Sits between the array and the output buffer/writeback path.

Parameters:
ARRAY_HEIGHT, `ARRAY_HEIGHT, rows in snapshot (number of output beats)
ARRAY_WIDTH, `ARRAY_WIDTH, columns (lanes per beat)
ACC_WIDTH, `ACC_WIDTH, signed accumulator width from array
OUT_WIDTH, 8, signed output lane width after requantization
SHIFT_W, $clog2(ACC_WIDTH), width of shift control

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
result_valid  in  1  one-cycle pulse from array: results matrix is final
results  in  [ARRAY_HEIGHT][ARRAY_WIDTH] x ACC_WIDTH signed  array accumulators
shift  in  SHIFT_W  right-shift amount, sampled at capture
acc_clear  out  1  one-cycle pulse to array accumulators
busy  out  1  snapshot held / streaming
out_valid  out  1  row beat valid
out_ready  in  1  downstream accepts beat
out_row  out  [ARRAY_WIDTH] x OUT_WIDTH signed  requantized row
out_row_idx  out  $clog2(ARRAY_HEIGHT) (min 1)  index of current row
out_last  out  1  high with the final row beat
overrun  out  1  sticky: result_valid arrived while busy
overrun_clear  in  1  clears overrun

Behaviour:
- Reset (async, active-high): state=IDLE; acc_clear=0; busy=0; out_valid=0; out_row_idx=0; out_last=0; overrun=0; snapshot and latched shift cleared to 0; out_row=0.
- States: IDLE, STREAM.
- Capture:
  - IDLE and result_valid=1 at edge N: all results and shift are registered.
  - At N+1: state=STREAM, busy=1, out_valid=1, out_row_idx=0, acc_clear=1 for exactly one cycle (N+1 only).
  - Latency from result_valid to first beat is 1 cycle.
- Streaming:
  - A beat transfers on a cycle where out_valid && out_ready.
  - On transfer with idx<ARRAY_HEIGHT-1: idx increments and out_valid stays 1.
  - On transfer with idx==ARRAY_HEIGHT-1: returns to IDLE; out_valid=0, busy=0, idx=0 next cycle.
- Handshake rules:
  - out_valid never drops without a transfer.
  - out_row, out_row_idx and out_last are stable while out_valid && !out_ready.
  - out_last = out_valid && idx==ARRAY_HEIGHT-1.
  - With out_ready held 1, rows stream on consecutive cycles: ARRAY_HEIGHT beats in ARRAY_HEIGHT cycles.
- Arithmetic, per lane, from snapshot[idx][c] with latched shift s:
  - s==0: v=acc.
  - s>0: v=(acc + 2^(s-1)) >>> s, computed in ACC_WIDTH+1 bits (round half up, arithmetic shift).
  - Saturate v to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - out_row is combinational from registered snapshot, idx and latched shift; no further pipeline stage.
- Overrun:
  - result_valid while busy=1, including the cycle of the final transfer, is ignored: no recapture, no acc_clear, snapshot unchanged.
  - That result_valid sets overrun=1.
  - overrun_clear=1 clears overrun next edge. If result_valid-while-busy and overrun_clear occur in the same cycle, set wins.
- shift changes after capture have no effect until the next capture.
- Reset mid-STREAM: immediate return to reset values; no further beats; no acc_clear.
- out_ready while out_valid=0 is ignored.

Decomposition:
- Shared package (npu_pkg):
  - drain_state_t enum {IDLE, STREAM}.
  - Saturation-bound constants derived from OUT_WIDTH.
  - Widths continue to come from defines.sv macros.
- Sub-module requant_sat: one lane of round-shift-saturate (ACC_WIDTH in, SHIFT_W shift, OUT_WIDTH out), purely combinational, instantiated ARRAY_WIDTH times in a generate loop.

Test Plan:
All scenarios use H=W=4, ACC_WIDTH=32, OUT_WIDTH=8.
1. Reset then idle 10 cycles -> all outputs 0; out_valid, acc_clear and busy never assert.
2. results[r][c]=4r+c, shift=0, result_valid pulse at N, out_ready=1 -> beats at N+1..N+4 carry rows {0,1,2,3}..{12,13,14,15}; idx 0..3; out_last only at N+4; acc_clear only at N+1; busy low at N+5.
3. Same stimulus, out_ready=0 for N+1..N+3 -> row 0 and idx=0 held stable for 3 cycles; transfer at N+4; last beat at N+7.
4. Requant lanes:
   - shift 0: acc 300 -> 127; acc -300 -> -128.
   - shift 1: acc 5 -> 3; acc -5 -> -2.
   - shift 2: acc 7 -> 2.
   - shift 4: acc 0x7FFFFFFF -> 127.
5. Second result_valid at N+2 during stream -> overrun=1 from N+3; rows still the original data; no extra acc_clear. overrun_clear pulse -> overrun=0 next cycle.
6. Assert rst at N+2 mid-stream -> out_valid, busy and idx are 0 immediately. A new result_valid after reset release starts a fresh stream from row 0.
